mux_2_1: RTL and testbench
==========================

MUX_2_1 -- requirements
Module: mux_2_1

Parameters
REQ-001 WIDTH, default 32: data path width in bits; legal values are 32 only when load formatting is used.

Interface
REQ-002 clk  input  1: single clock; all sequential elements update on its rising edge.
REQ-003 reset  input  1: reset is synchronous and active-high.
REQ-004 data_mem  input  WIDTH: raw load data from the memory stage.
REQ-005 data_alu  input  WIDTH: ALU result.
REQ-006 MemToReg_m  input  1: select; 1 = memory data, 0 = ALU data.
REQ-007 mem_size  input  2: load size; 00 = word, 01 = halfword, 10 = byte, 11 = reserved (treated as word).
REQ-008 mem_unsigned  input  1: 1 = zero-extend sub-word loads; 0 = sign-extend.
REQ-009 addr_lo  input  2: low address bits selecting the byte or halfword lane, little-endian.
REQ-010 valid_in  input  1: the current inputs form a valid writeback.
REQ-011 stall  input  1: hold the registered stage.
REQ-012 flush  input  1: invalidate the registered stage.
REQ-013 output_data  output  WIDTH: combinational selected result.
REQ-014 output_data_q  output  WIDTH: registered copy of output_data.
REQ-015 valid_q  output  1: the registered result is valid.

Function
REQ-016 Formatted memory data (fmt_mem) SHALL be computed as follows:
- Word: data_mem unchanged.
- Halfword: data_mem[15:0] when addr_lo[1]=0, else data_mem[31:16].
- Byte: data_mem byte lane addr_lo, with lane 0 = bits [7:0].
REQ-017 Sub-word results SHALL be extended to WIDTH, with zeros when mem_unsigned=1 and with the lane's MSB otherwise.
REQ-018 For halfword loads, addr_lo[0] SHALL be ignored; misaligned accesses are not flagged.
REQ-019 output_data SHALL equal fmt_mem when MemToReg_m=1, else data_alu.
REQ-020 output_data SHALL be purely combinational: zero-cycle latency, independent of clk, reset, valid_in, stall and flush.
REQ-021 When MemToReg_m=0, output_data SHALL be unaffected by data_mem, mem_size, mem_unsigned and addr_lo.
REQ-022 On each rising edge with reset=0, the registered stage SHALL update in priority order:
- flush=1: valid_q<=0, output_data_q<=0.
- else stall=1: output_data_q and valid_q hold.
- else: output_data_q<=output_data, valid_q<=valid_in.
REQ-023 The registered stage SHALL have a latency of exactly one cycle.
REQ-024 output_data_q SHALL update whenever the stage is not stalled or flushed, regardless of valid_in.
REQ-025 No arithmetic is performed; no carries, and no truncation except the lane selection in REQ-016.

Reset
REQ-026 While reset=1 at a rising edge, output_data_q SHALL become 0 and valid_q SHALL become 0.
REQ-027 Reset SHALL take priority over flush and stall.
REQ-028 Reset SHALL NOT affect output_data, which keeps following its inputs combinationally during reset.
REQ-029 Deasserting reset mid-stream SHALL resume capture on the first edge with reset=0.

Structure
REQ-030 A shared package SHALL hold:
- The mem_size encodings SIZE_WORD=00, SIZE_HALF=01 and SIZE_BYTE=10.
- A default WIDTH constant of 32.
REQ-031 Load formatting SHALL be a sub-module named load_formatter (inputs data_mem, mem_size, mem_unsigned, addr_lo; output fmt_mem).
REQ-032 The select mux and the registered stage SHALL reside in mux_2_1.

Verification
REQ-033 Word select, ALU path: data_mem=43, data_alu=102, MemToReg_m=0, mem_size=00 -> output_data=102 immediately.
REQ-034 Word select, memory path: data_mem=343, data_alu=344, MemToReg_m=1, mem_size=00 -> output_data=343 immediately; output_data_q=343 one edge later.
REQ-035 Sub-word extension: data_mem=0x8081_F0FF, MemToReg_m=1, in turn:
- byte, addr_lo=1, signed -> output_data=0xFFFF_FFF0.
- byte, addr_lo=1, unsigned -> 0x0000_00F0.
- half, addr_lo=2, signed -> 0xFFFF_8081.
REQ-036 Registered-stage controls: valid_in=1 captured; then stall=1 with changed inputs -> output_data_q and valid_q hold; then flush=1 together with stall=1 -> valid_q=0 and output_data_q=0 next edge.
REQ-037 Reset mid-operation: reset=1 asserted while valid_q=1 -> valid_q=0 and output_data_q=0 after one edge, with output_data still tracking inputs.

Source files
------------

// File: rtl/mux_2_1_pkg.sv
// Shared constants for the writeback select stage: load size encodings and default width.
package mux_2_1_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

endpackage

// File: rtl/load_formatter.sv
// Little-endian lane extraction and sign/zero extension of raw load data.
module load_formatter
  import mux_2_1_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data_mem,
  input  logic [1:0]       mem_size,
  input  logic             mem_unsigned,
  input  logic [1:0]       addr_lo,
  output logic [WIDTH-1:0] fmt_mem
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword lane ignores addr_lo[0]; misalignment is silently accepted.
  always_comb begin
    w_half = addr_lo[1] ? data_mem[31:16] : data_mem[15:0];
    w_byte = data_mem[7:0];
    case (addr_lo)
      2'd1:    w_byte = data_mem[15:8];
      2'd2:    w_byte = data_mem[23:16];
      2'd3:    w_byte = data_mem[31:24];
      default: w_byte = data_mem[7:0];
    endcase
  end

  always_comb begin
    fmt_mem = data_mem;
    case (mem_size)
      SIZE_HALF: fmt_mem = {{(WIDTH-16){~mem_unsigned & w_half[15]}}, w_half};
      SIZE_BYTE: fmt_mem = {{(WIDTH-8){~mem_unsigned & w_byte[7]}}, w_byte};
      default:   fmt_mem = data_mem;
    endcase
  end

endmodule

// File: rtl/mux_2_1.sv
// Writeback select between formatted load data and ALU result, plus one registered copy.
module mux_2_1
  import mux_2_1_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_mem,
  input  logic [WIDTH-1:0] data_alu,
  input  logic             MemToReg_m,
  input  logic [1:0]       mem_size,
  input  logic             mem_unsigned,
  input  logic [1:0]       addr_lo,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] output_data,
  output logic [WIDTH-1:0] output_data_q,
  output logic             valid_q
);

  logic [WIDTH-1:0] w_fmt_mem;
  logic [WIDTH-1:0] r_data_q;
  logic             r_valid_q;

  load_formatter #(.WIDTH(WIDTH)) u_load_formatter (
    .data_mem     (data_mem),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .addr_lo      (addr_lo),
    .fmt_mem      (w_fmt_mem)
  );

  assign output_data = MemToReg_m ? w_fmt_mem : data_alu;

  // Priority: reset, flush, stall, capture (data captured regardless of valid_in).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else if (flush) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else if (!stall) begin
      r_data_q  <= output_data;
      r_valid_q <= valid_in;
    end
  end

  assign output_data_q = r_data_q;
  assign valid_q       = r_valid_q;

endmodule

// File: tb/tb_mux_2_1.sv
// Directed self-checking bench for mux_2_1: select, load formatting and registered stage.
module tb_mux_2_1;

  logic        clk;
  logic        reset;
  logic [31:0] data_mem;
  logic [31:0] data_alu;
  logic        MemToReg_m;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [1:0]  addr_lo;
  logic        valid_in;
  logic        stall;
  logic        flush;
  logic [31:0] output_data;
  logic [31:0] output_data_q;
  logic        valid_q;

  int n_checks = 0;
  int n_errors = 0;

  mux_2_1 #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_mem      (data_mem),
    .data_alu      (data_alu),
    .MemToReg_m    (MemToReg_m),
    .mem_size      (mem_size),
    .mem_unsigned  (mem_unsigned),
    .addr_lo       (addr_lo),
    .valid_in      (valid_in),
    .stall         (stall),
    .flush         (flush),
    .output_data   (output_data),
    .output_data_q (output_data_q),
    .valid_q       (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fmt(input logic [1:0] sz, input logic uns, input logic [1:0] lo);
    mem_size     = sz;
    mem_unsigned = uns;
    addr_lo      = lo;
    #1;
  endtask

  initial begin
    reset = 1'b1; data_mem = '0; data_alu = '0; MemToReg_m = 1'b0;
    mem_size = 2'b00; mem_unsigned = 1'b0; addr_lo = 2'b00;
    valid_in = 1'b1; stall = 1'b0; flush = 1'b0;
    tick();
    tick();
    check("reset_data_q", output_data_q, 32'h0);
    check("reset_valid_q", {31'b0, valid_q}, 32'h0);

    reset = 1'b0;
    data_mem = 32'd43; data_alu = 32'd102; MemToReg_m = 1'b0; valid_in = 1'b0;
    #1;
    check("alu_path", output_data, 32'd102);

    data_mem = 32'd343; data_alu = 32'd344; MemToReg_m = 1'b1; valid_in = 1'b1;
    #1;
    check("mem_path", output_data, 32'd343);
    tick();
    check("mem_path_q", output_data_q, 32'd343);
    check("mem_path_valid", {31'b0, valid_q}, 32'h1);

    data_mem = 32'h8081_F0FF;
    set_fmt(2'b10, 1'b0, 2'd1); check("byte1_signed", output_data, 32'hFFFF_FFF0);
    set_fmt(2'b10, 1'b1, 2'd1); check("byte1_unsigned", output_data, 32'h0000_00F0);
    set_fmt(2'b01, 1'b0, 2'd2); check("half2_signed", output_data, 32'hFFFF_8081);
    set_fmt(2'b01, 1'b1, 2'd2); check("half2_unsigned", output_data, 32'h0000_8081);
    set_fmt(2'b01, 1'b0, 2'd3); check("half3_ignore_lsb", output_data, 32'hFFFF_8081);
    set_fmt(2'b01, 1'b0, 2'd0); check("half0_signed", output_data, 32'hFFFF_F0FF);
    set_fmt(2'b01, 1'b0, 2'd1); check("half1_ignore_lsb", output_data, 32'hFFFF_F0FF);
    set_fmt(2'b10, 1'b1, 2'd0); check("byte0_unsigned", output_data, 32'h0000_00FF);
    set_fmt(2'b10, 1'b0, 2'd2); check("byte2_signed", output_data, 32'hFFFF_FF81);
    set_fmt(2'b10, 1'b0, 2'd3); check("byte3_signed", output_data, 32'hFFFF_FF80);
    set_fmt(2'b10, 1'b1, 2'd3); check("byte3_unsigned", output_data, 32'h0000_0080);
    set_fmt(2'b11, 1'b0, 2'd1); check("reserved_as_word", output_data, 32'h8081_F0FF);
    set_fmt(2'b00, 1'b1, 2'd2); check("word_unsigned", output_data, 32'h8081_F0FF);

    MemToReg_m = 1'b0; data_alu = 32'hDEAD_BEEF;
    set_fmt(2'b10, 1'b0, 2'd3); check("alu_ignores_fmt", output_data, 32'hDEAD_BEEF);

    data_alu = 32'h0000_1234; valid_in = 1'b1; set_fmt(2'b00, 1'b0, 2'd0);
    tick();
    check("capture_q", output_data_q, 32'h0000_1234);
    check("capture_valid", {31'b0, valid_q}, 32'h1);

    stall = 1'b1; data_alu = 32'h0000_5678; valid_in = 1'b0;
    #1;
    check("stall_comb_follows", output_data, 32'h0000_5678);
    tick();
    check("stall_hold_q", output_data_q, 32'h0000_1234);
    check("stall_hold_valid", {31'b0, valid_q}, 32'h1);

    flush = 1'b1;
    tick();
    check("flush_q", output_data_q, 32'h0);
    check("flush_valid", {31'b0, valid_q}, 32'h0);

    flush = 1'b0; stall = 1'b0; data_alu = 32'h0000_00AA; valid_in = 1'b0;
    tick();
    check("invalid_capture_q", output_data_q, 32'h0000_00AA);
    check("invalid_capture_valid", {31'b0, valid_q}, 32'h0);

    data_alu = 32'h0000_00BB; valid_in = 1'b1;
    tick();
    check("pre_reset_valid", {31'b0, valid_q}, 32'h1);

    reset = 1'b1; stall = 1'b1; data_alu = 32'h0000_00CC;
    #1;
    check("reset_comb_follows", output_data, 32'h0000_00CC);
    tick();
    check("midreset_q", output_data_q, 32'h0);
    check("midreset_valid", {31'b0, valid_q}, 32'h0);

    reset = 1'b0; stall = 1'b0; data_alu = 32'h0000_00DD;
    tick();
    check("resume_q", output_data_q, 32'h0000_00DD);
    check("resume_valid", {31'b0, valid_q}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
